jump_fu_sched: RTL and testbench
================================

# jump_fu_sched

Issue scheduler and writeback sequencer for the branch/jump functional unit. It arbitrates round-robin among NREQ reservation-station requesters and drives the unit's operand and enable inputs. It captures the unit's one-cycle result, then presents the link value on the writeback port with a valid/ready handshake and pulses a fetch redirect for taken jumps. It sits between the jump reservation stations and the common writeback path, and honours pipeline flush at any point.

## Interface
- NREQ, 2: number of requesters (≥2).
- TAG_W, 3: destination tag width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard in-flight operation.
- req  in  NREQ  per-requester issue request (level).
- req_tag  in  NREQ*TAG_W  packed tags, requester i at [i*TAG_W +: TAG_W].
- req_jalr  in  NREQ  JALR select per requester.
- req_cmp_ctrl  in  NREQ*4  packed compare control.
- req_rs1, req_rs2, req_imm, req_pc  in  NREQ*32 each  packed operands.
- grant  out  NREQ  one-hot, one-cycle accept pulse.
- fu_en  out  1  unit enable.
- fu_jalr  out  1  operand to unit.
- fu_cmp_ctrl  out  4  operand to unit.
- fu_rs1, fu_rs2, fu_imm, fu_pc  out  32 each  operands to unit.
- fu_pc_jump  in  32  unit target result.
- fu_pc_wb  in  32  unit link result.
- fu_is_jump  in  1  unit taken result.
- fu_finish  in  1  unit done, one cycle.
- wb_valid  out  1  writeback valid.
- wb_tag  out  TAG_W  writeback tag.
- wb_data  out  32  link value (PC+4).
- wb_ready  in  1  writeback accepted.
- redirect_valid  out  1  one-cycle taken pulse.
- redirect_pc  out  32  jump target.
- busy  out  1  state ≠ IDLE.

## Operation
- Unit contract:
  - The unit samples operands on an edge where fu_en=1 and the unit is idle.
  - It raises fu_finish for exactly the next cycle, with results valid in that cycle.
  - fu_en asserted while fu_finish=1 is ignored by the unit and is forbidden here.
- FSM states: IDLE, ISSUE, EXEC, WB.
- IDLE:
  - Grant condition: any req, flush=0 and fu_finish=0.
  - Select the winner w as the first set req at or after ptr, searching modulo NREQ.
  - grant[w]=1 combinationally in that cycle.
  - Latch w's tag and operands into internal registers; ptr←(w+1) mod NREQ.
  - Next state ISSUE.
- ISSUE:
  - fu_en=1 (decoded from state); fu_* driven from the latched registers.
  - fu_* hold their latched values in every state and are 0 after reset.
  - Next state EXEC.
- EXEC:
  - Wait for fu_finish=1.
  - On finish, capture fu_pc_jump, fu_pc_wb and fu_is_jump; next state WB.
- WB:
  - wb_valid=1, wb_tag=latched tag, wb_data=captured pc_wb.
  - redirect_valid=1 only in the first WB cycle, and only if captured is_jump=1; redirect_pc=captured pc_jump, held.
  - When wb_ready=1, next state IDLE.
- flush has priority in every state:
  - The next state is IDLE and the latched operation is discarded.
  - No wb_valid or redirect for the discarded operation.
  - A fu_finish arriving outside EXEC is ignored.
- Simultaneous flush and wb_ready in WB: treated as flush; the result counts as discarded.
- Reset (asynchronous, any state):
  - State IDLE, ptr=0.
  - All registered outputs 0: fu_*, wb_tag, wb_data, redirect_pc.
  - grant, fu_en, wb_valid, redirect_valid and busy are 0.
- NREQ not a power of two: ptr wraps from NREQ-1 to 0.

## Timing
- Request sampled in IDLE at cycle T: grant at T, fu_en at T+1, fu_finish at T+2, wb_valid and redirect at T+3.
- wb_ready at T+3 returns the FSM to IDLE at T+4; maximum throughput is one operation per 4 cycles.
- wb_valid and all wb fields stay stable until wb_ready or flush.
- Flush in ISSUE: the unit has still started, so fu_finish arrives in the following IDLE cycle. The grant is blocked that cycle and the earliest new grant is one cycle later.
- Requesters must hold req and operands stable until granted. Dropping req before grant is allowed, and that requester is then simply not selected.

## Test plan
- Single request: req=01, pc=0x100, imm=0x20, cmp_ctrl=0001, jalr=0; unit returns pc_jump=0x120, pc_wb=0x104, is_jump=1. Required: grant=01 at T, fu_en at T+1, wb_valid with wb_data=0x104 at T+3, one-cycle redirect to 0x120.
- Not-taken branch: is_jump=0. Required: wb_valid asserted, redirect_valid never 1.
- Round robin: req=11 held continuously from reset. Required: grants alternate 01, 10, 01, each 4 cycles apart with wb_ready tied 1.
- Backpressure: wb_ready=0 for 5 cycles in WB. Required: wb fields stable, redirect pulses once only, no new grant until wb_ready=1.
- Flush in ISSUE with req held: fu_finish the next cycle is ignored, no grant that cycle, a grant the cycle after, and no wb for the flushed operation.
- Reset asserted in EXEC: all outputs 0 immediately; after release, a new request completes normally with ptr starting at 0.

Source files
------------

// File: rtl/jump_fu_sched.sv
// ============================================================================
// Module   : jump_fu_sched
// Purpose  : Round-robin issue scheduler and writeback/redirect sequencer
//            for the branch/jump functional unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jump_fu_sched #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ-1:0]       req_jalr,
  input  logic [NREQ*4-1:0]     req_cmp_ctrl,
  input  logic [NREQ*32-1:0]    req_rs1,
  input  logic [NREQ*32-1:0]    req_rs2,
  input  logic [NREQ*32-1:0]    req_imm,
  input  logic [NREQ*32-1:0]    req_pc,
  output logic [NREQ-1:0]       grant,
  output logic                  fu_en,
  output logic                  fu_jalr,
  output logic [3:0]            fu_cmp_ctrl,
  output logic [31:0]           fu_rs1,
  output logic [31:0]           fu_rs2,
  output logic [31:0]           fu_imm,
  output logic [31:0]           fu_pc,
  input  logic [31:0]           fu_pc_jump,
  input  logic [31:0]           fu_pc_wb,
  input  logic                  fu_is_jump,
  input  logic                  fu_finish,
  output logic                  wb_valid,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [31:0]           wb_data,
  input  logic                  wb_ready,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  busy
);

  localparam int c_ptr_w = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_ptr_w-1:0] r_ptr;
  logic [TAG_W-1:0]   r_tag;
  logic               r_jalr;
  logic [3:0]         r_cmp_ctrl;
  logic [31:0]        r_rs1, r_rs2, r_imm, r_pc;
  logic [31:0]        r_pc_jump, r_pc_wb;
  logic               r_is_jump;
  logic               r_first;

  logic [c_ptr_w-1:0] w_cand, w_win, w_ptr_nxt;
  logic               w_found, w_grant_ok;

  // First set request at or after the pointer, searching modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = c_ptr_w'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_ptr_nxt  = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  // A unit finish in IDLE belongs to a flushed issue; never overlap it with a new grant.
  assign w_grant_ok = rst_n && (r_state == IDLE) && w_found && !flush && !fu_finish;
  assign grant      = w_grant_ok ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_tag      <= '0;
      r_jalr     <= 1'b0;
      r_cmp_ctrl <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_pc_jump  <= '0;
      r_pc_wb    <= '0;
      r_is_jump  <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_ok) begin
            r_tag      <= req_tag[int'(w_win)*TAG_W +: TAG_W];
            r_jalr     <= req_jalr[w_win];
            r_cmp_ctrl <= req_cmp_ctrl[int'(w_win)*4 +: 4];
            r_rs1      <= req_rs1[int'(w_win)*32 +: 32];
            r_rs2      <= req_rs2[int'(w_win)*32 +: 32];
            r_imm      <= req_imm[int'(w_win)*32 +: 32];
            r_pc       <= req_pc[int'(w_win)*32 +: 32];
            r_ptr      <= w_ptr_nxt;
            r_state    <= ISSUE;
          end
        end
        ISSUE: r_state <= flush ? IDLE : EXEC;
        EXEC: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (fu_finish) begin
            r_pc_jump <= fu_pc_jump;
            r_pc_wb   <= fu_pc_wb;
            r_is_jump <= fu_is_jump;
            r_first   <= 1'b1;
            r_state   <= WB;
          end
        end
        WB: begin
          if (flush || wb_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fu_en       = (r_state == ISSUE);
  assign fu_jalr     = r_jalr;
  assign fu_cmp_ctrl = r_cmp_ctrl;
  assign fu_rs1      = r_rs1;
  assign fu_rs2      = r_rs2;
  assign fu_imm      = r_imm;
  assign fu_pc       = r_pc;

  // Flush wins over a same-cycle wb_ready, so the result is hidden from the consumer.
  assign wb_valid       = (r_state == WB) && !flush;
  assign wb_tag         = r_tag;
  assign wb_data        = r_pc_wb;
  assign redirect_valid = (r_state == WB) && r_first && r_is_jump && !flush;
  assign redirect_pc    = r_pc_jump;
  assign busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_jump_fu_sched.sv
// ============================================================================
// Module   : tb_jump_fu_sched
// Purpose  : Directed self-checking bench for jump_fu_sched with a one-cycle
//            behavioural jump unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jump_fu_sched;
  localparam int NREQ  = 2;
  localparam int TAG_W = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*TAG_W-1:0] req_tag = '0;
  logic [NREQ-1:0]       req_jalr = '0;
  logic [NREQ*4-1:0]     req_cmp_ctrl = '0;
  logic [NREQ*32-1:0]    req_rs1 = '0, req_rs2 = '0, req_imm = '0, req_pc = '0;
  logic [NREQ-1:0]       grant;
  logic                  fu_en, fu_jalr;
  logic [3:0]            fu_cmp_ctrl;
  logic [31:0]           fu_rs1, fu_rs2, fu_imm, fu_pc;
  logic [31:0]           fu_pc_jump, fu_pc_wb;
  logic                  fu_is_jump, fu_finish;
  logic                  wb_valid;
  logic [TAG_W-1:0]      wb_tag;
  logic [31:0]           wb_data;
  logic                  wb_ready = 1'b0;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  busy;

  logic unit_taken = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   redirect_cnt = 0;

  jump_fu_sched #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .req_tag(req_tag),
    .req_jalr(req_jalr), .req_cmp_ctrl(req_cmp_ctrl), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc), .grant(grant),
    .fu_en(fu_en), .fu_jalr(fu_jalr), .fu_cmp_ctrl(fu_cmp_ctrl), .fu_rs1(fu_rs1),
    .fu_rs2(fu_rs2), .fu_imm(fu_imm), .fu_pc(fu_pc), .fu_pc_jump(fu_pc_jump),
    .fu_pc_wb(fu_pc_wb), .fu_is_jump(fu_is_jump), .fu_finish(fu_finish),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ready(wb_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural unit: samples on fu_en, finishes exactly one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_finish  <= 1'b0;
      fu_pc_jump <= '0;
      fu_pc_wb   <= '0;
      fu_is_jump <= 1'b0;
    end else begin
      fu_finish  <= fu_en && !fu_finish;
      fu_pc_jump <= fu_jalr ? fu_rs1 + fu_imm : fu_pc + fu_imm;
      fu_pc_wb   <= fu_pc + 32'd4;
      fu_is_jump <= unit_taken;
    end
  end

  always @(negedge clk) if (redirect_valid) redirect_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [TAG_W-1:0] tag, input logic jalr,
                        input logic [3:0] cmp, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
    req_tag[i*TAG_W +: TAG_W] = tag;
    req_jalr[i]               = jalr;
    req_cmp_ctrl[i*4 +: 4]    = cmp;
    req_rs1[i*32 +: 32]       = rs1;
    req_rs2[i*32 +: 32]       = rs2;
    req_imm[i*32 +: 32]       = imm;
    req_pc[i*32 +: 32]        = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fu_en !== 1'b0) begin failures++; $display("FAIL reset_fu_en got=%b exp=0", fu_en); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (fu_pc !== 32'h0) begin failures++; $display("FAIL reset_fu_pc got=%h exp=0", fu_pc); end
    checks++; if (wb_tag !== 3'h0) begin failures++; $display("FAIL reset_wb_tag got=%h exp=0", wb_tag); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int r0;
    set_op(0, 3'd5, 1'b0, 4'b0001, 32'h11, 32'h22, 32'h20, 32'h100);
    unit_taken = 1'b1;
    wb_ready   = 1'b1;
    r0 = redirect_cnt;
    tick(); req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant); end
    checks++; if (fu_en !== 1'b0) begin failures++; $display("FAIL single_fu_en_T got=%b exp=0", fu_en); end
    tick(); req = 2'b00; #1;
    checks++; if (fu_en !== 1'b1) begin failures++; $display("FAIL single_fu_en_T1 got=%b exp=1", fu_en); end
    checks++; if (fu_pc !== 32'h100 || fu_imm !== 32'h20) begin failures++; $display("FAIL single_fu_ops got=%h/%h exp=100/20", fu_pc, fu_imm); end
    checks++; if (fu_cmp_ctrl !== 4'b0001 || fu_jalr !== 1'b0 || fu_rs1 !== 32'h11 || fu_rs2 !== 32'h22) begin
      failures++; $display("FAIL single_fu_ctrl got=%b/%b/%h/%h exp=0001/0/11/22", fu_cmp_ctrl, fu_jalr, fu_rs1, fu_rs2); end
    tick();
    checks++; if (fu_en !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL single_T2 got=%b/%b exp=0/0", fu_en, wb_valid); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h104 || wb_tag !== 3'd5) begin
      failures++; $display("FAIL single_wb got=%b/%h/%h exp=1/104/5", wb_valid, wb_data, wb_tag); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
      failures++; $display("FAIL single_redirect got=%b/%h exp=1/120", redirect_valid, redirect_pc); end
    tick();
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got=%b/%b exp=0/0", wb_valid, busy); end
    checks++; if (redirect_cnt - r0 !== 1) begin failures++; $display("FAIL single_redirect_count got=%0d exp=1", redirect_cnt - r0); end
  endtask

  task automatic test_not_taken();
    int r0;
    set_op(1, 3'd2, 1'b1, 4'b0000, 32'h200, 32'h0, 32'h8, 32'h300);
    unit_taken = 1'b0;
    r0 = redirect_cnt;
    tick(); req = 2'b10; #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL nt_grant got=%b exp=10", grant); end
    tick(); req = 2'b00; #1;
    checks++; if (fu_jalr !== 1'b1 || fu_pc !== 32'h300) begin failures++; $display("FAIL nt_fu_ops got=%b/%h exp=1/300", fu_jalr, fu_pc); end
    tick();
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h304 || wb_tag !== 3'd2) begin
      failures++; $display("FAIL nt_wb got=%b/%h/%h exp=1/304/2", wb_valid, wb_data, wb_tag); end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h208) begin
      failures++; $display("FAIL nt_redirect got=%b/%h exp=0/208", redirect_valid, redirect_pc); end
    tick();
    checks++; if (redirect_cnt - r0 !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL nt_done got=%0d/%b exp=0/0", redirect_cnt - r0, busy); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    logic [31:0]     exp_d;
    rst_n = 1'b0;
    set_op(0, 3'd1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h4, 32'h1000);
    set_op(1, 3'd6, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h4, 32'h2000);
    req = 2'b11;
    wb_ready = 1'b1;
    unit_taken = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) rst_n = 1'b1;
      if (k == 9) req = 2'b00;
      #1;
      exp_g = (k % 4 == 0 && k < 9) ? (((k / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
      if (k % 4 == 3) begin
        exp_d = ((k / 4) % 2 == 0) ? 32'h1004 : 32'h2004;
        checks++; if (wb_valid !== 1'b1 || wb_data !== exp_d) begin
          failures++; $display("FAIL rr_wb k=%0d got=%b/%h exp=1/%h", k, wb_valid, wb_data, exp_d); end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int r0;
    set_op(0, 3'd4, 1'b0, 4'b0010, 32'h0, 32'h0, 32'h40, 32'h500);
    unit_taken = 1'b1;
    wb_ready = 1'b0;
    r0 = redirect_cnt;
    tick(); req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL bp_grant_wrap got=%b exp=01", grant); end
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h504 || wb_tag !== 3'd4 || redirect_pc !== 32'h540) begin
        failures++; $display("FAIL bp_stable k=%0d got=%b/%h/%h/%h exp=1/504/4/540", k, wb_valid, wb_data, wb_tag, redirect_pc); end
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL bp_no_grant k=%0d got=%b exp=00", k, grant); end
    end
    checks++; if (redirect_cnt - r0 !== 1) begin failures++; $display("FAIL bp_redirect_once got=%0d exp=1", redirect_cnt - r0); end
    tick(); wb_ready = 1'b1; #1;
    checks++; if (wb_valid !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL bp_accept got=%b/%b exp=1/00", wb_valid, grant); end
    tick();
    checks++; if (grant !== 2'b01 || wb_valid !== 1'b0) begin failures++; $display("FAIL bp_regrant got=%b/%b exp=01/0", grant, wb_valid); end
    tick(); req = 2'b00;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", busy); end
  endtask

  task automatic test_flush_issue();
    int r0;
    set_op(0, 3'd1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h4, 32'h600);
    set_op(1, 3'd7, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h4, 32'h700);
    unit_taken = 1'b1;
    wb_ready = 1'b1;
    r0 = redirect_cnt;
    tick(); req = 2'b11; #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL fl_grant got=%b exp=10", grant); end
    tick(); flush = 1'b1; #1;
    checks++; if (fu_en !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL fl_issue got=%b/%b exp=1/0", fu_en, wb_valid); end
    tick(); flush = 1'b0; #1;
    checks++; if (fu_finish !== 1'b1 || grant !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL fl_blocked got=%b/%b/%b exp=1/00/0", fu_finish, grant, busy); end
    tick();
    checks++; if (grant !== 2'b01 || wb_valid !== 1'b0) begin failures++; $display("FAIL fl_next_grant got=%b/%b exp=01/0", grant, wb_valid); end
    tick(); req = 2'b00; #1;
    checks++; if (fu_en !== 1'b1 || fu_pc !== 32'h600) begin failures++; $display("FAIL fl_new_issue got=%b/%h exp=1/600", fu_en, fu_pc); end
    tick();
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_tag !== 3'd1 || wb_data !== 32'h604) begin
      failures++; $display("FAIL fl_new_wb got=%b/%h/%h exp=1/1/604", wb_valid, wb_tag, wb_data); end
    tick();
    checks++; if (redirect_cnt - r0 !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL fl_redirects got=%0d/%b exp=1/0", redirect_cnt - r0, busy); end
  endtask

  task automatic test_reset_exec();
    set_op(0, 3'd3, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h10, 32'h800);
    set_op(1, 3'd6, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h10, 32'h900);
    unit_taken = 1'b1;
    wb_ready = 1'b1;
    tick(); req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rx_grant got=%b exp=01", grant); end
    tick(); req = 2'b00;
    tick(); rst_n = 1'b0; req = 2'b11; #1;
    checks++; if (busy !== 1'b0 || fu_en !== 1'b0 || grant !== 2'b00 || wb_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++; $display("FAIL rx_ctrl_zero got=%b/%b/%b/%b/%b exp=0/0/00/0/0", busy, fu_en, grant, wb_valid, redirect_valid); end
    checks++; if (fu_pc !== 32'h0 || fu_imm !== 32'h0 || wb_data !== 32'h0 || redirect_pc !== 32'h0 || wb_tag !== 3'h0) begin
      failures++; $display("FAIL rx_data_zero got=%h/%h/%h/%h/%h exp=0", fu_pc, fu_imm, wb_data, redirect_pc, wb_tag); end
    tick();
    tick(); rst_n = 1'b1; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rx_ptr_zero got=%b exp=01", grant); end
    tick(); req = 2'b00;
    tick();
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h804 || wb_tag !== 3'd3 || redirect_pc !== 32'h810) begin
      failures++; $display("FAIL rx_complete got=%b/%h/%h/%h exp=1/804/3/810", wb_valid, wb_data, wb_tag, redirect_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_not_taken();
    test_round_robin();
    test_backpressure();
    test_flush_issue();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
